vegeta_array_sequencer: RTL

- Sequences a NUM_ROWS x NUM_COLS weight-stationary array of double-buffered sparse MAC PEs through a job of `num_tiles` weight tiles.
- Drives the array-wide `mode`, `weight_transferring`, and `i_wb` controls, and handshakes the weight stream and activation stream sources.
- Overlaps the next tile's weight preload (into the shadow buffer) with the current tile's compute, then swaps buffers.
- Sits between the job-issue logic and the PE array.

---
 rtl/vegeta_seq_pkg.sv | 18 +
 rtl/vegeta_seq_beat_cnt.sv | 32 +++
 rtl/vegeta_array_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/vegeta_seq_pkg.sv
// Shared types and helpers for the VEGETA array sequencer.
// Holds the FSM state encoding and the default drain-length function.
package vegeta_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD0,
        COMPUTE,
        DRAIN,
        WAIT_W,
        DONE
    } seq_state_e;

    function automatic int drain_cycles(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/vegeta_seq_beat_cnt.sv
// Saturating beat counter with clear, enable and terminal compare.
// 'last' flags the enabled beat that brings the count to 'term'.
module vegeta_seq_beat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         at_term,
    output logic         last
);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_inc;

    assign cnt_inc = cnt + W'(1);
    assign at_term = (cnt == term);
    assign last    = en && !at_term && (cnt_inc == term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !at_term) begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/vegeta_array_sequencer.sv
// Tile sequencer for a weight-stationary double-buffered sparse MAC array.
// Optional perf counters are enabled with `define VEGETA_SEQ_PERF_CNT_EN.
module vegeta_array_sequencer
    import vegeta_seq_pkg::*;
#(
    parameter int NUM_ROWS     = 4,
    parameter int NUM_COLS     = 4,
    parameter int TILE_W       = 8,
    parameter int ACT_W        = 12,
    parameter int DRAIN_CYCLES = drain_cycles(NUM_ROWS, NUM_COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic [ACT_W-1:0]  act_len,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic              act_valid,
    output logic              act_ready,
    output logic              mode,
    output logic              weight_transferring,
    output logic              i_wb,
    output logic              busy,
    output logic              done,
`ifdef VEGETA_SEQ_PERF_CNT_EN
    output logic [31:0]       perf_wstall_cycles,
    output logic [31:0]       perf_astall_cycles,
`endif
    output logic [TILE_W-1:0] tile_idx
);

    localparam int WCW = $clog2(NUM_ROWS + 1);
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [WCW-1:0] W_TERM = WCW'(NUM_ROWS);
    localparam logic [DCW-1:0] D_TERM = DCW'(DRAIN_CYCLES);

    seq_state_e state, next_state;

    logic [TILE_W-1:0] nt_q;
    logic [ACT_W-1:0]  al_q;
    logic [TILE_W:0]   tile_nxt;

    logic has_next, load_en, start_acc, swap;
    logic w_beat, a_beat, w_clr, d_end_clr;
    logic w_at_term, w_last;
    logic a_at_term, a_last;
    logic d_at_term, d_last;
    logic unused_ok;

    assign tile_nxt = {1'b0, tile_idx} + (TILE_W + 1)'(1);
    assign has_next = tile_nxt < {1'b0, nt_q};

    assign w_beat              = w_valid && load_en;
    assign w_ready             = w_beat;
    assign weight_transferring = w_beat;
    assign act_ready           = (state == COMPUTE);
    assign a_beat              = act_valid && act_ready;
    assign mode = (state == COMPUTE) || (state == DRAIN) || (state == WAIT_W);
    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign unused_ok = a_at_term ^ d_at_term;

    always_comb begin
        next_state = state;
        load_en    = 1'b0;
        start_acc  = 1'b0;
        swap       = 1'b0;
        w_clr      = 1'b0;
        d_end_clr  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    next_state = (num_tiles == '0) ? DONE : LOAD0;
                end
            end
            LOAD0: begin
                load_en = 1'b1;
                if (w_last) begin
                    w_clr      = 1'b1;
                    next_state = COMPUTE;
                end
            end
            COMPUTE: begin
                load_en = has_next && !w_at_term;
                if (a_last) next_state = DRAIN;
            end
            DRAIN: begin
                load_en = has_next && !w_at_term;
                if (d_last) begin
                    d_end_clr = 1'b1;
                    if (!has_next) begin
                        next_state = DONE;
                    end else if (w_at_term || w_last) begin
                        swap       = 1'b1;
                        next_state = COMPUTE;
                    end else begin
                        next_state = WAIT_W;
                    end
                end
            end
            // mode stays 1 here so late beats land in the shadow buffer
            WAIT_W: begin
                load_en = !w_at_term;
                if (w_at_term || w_last) begin
                    swap       = 1'b1;
                    next_state = COMPUTE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            nt_q     <= '0;
            al_q     <= '0;
            tile_idx <= '0;
            i_wb     <= 1'b0;
        end else begin
            state <= next_state;
            if (start_acc) begin
                nt_q     <= num_tiles;
                al_q     <= (act_len == '0) ? ACT_W'(1) : act_len;
                tile_idx <= '0;
                if (num_tiles != '0) i_wb <= 1'b0;
            end else if (swap) begin
                i_wb     <= ~i_wb;
                tile_idx <= tile_nxt[TILE_W-1:0];
            end
        end
    end

    vegeta_seq_beat_cnt #(.W(WCW)) u_w_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start_acc || w_clr || swap),
        .en      (w_beat),
        .term    (W_TERM),
        .at_term (w_at_term),
        .last    (w_last)
    );

    vegeta_seq_beat_cnt #(.W(ACT_W)) u_a_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start_acc || swap),
        .en      (a_beat),
        .term    (al_q),
        .at_term (a_at_term),
        .last    (a_last)
    );

    vegeta_seq_beat_cnt #(.W(DCW)) u_d_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start_acc || d_end_clr || swap),
        .en      (state == DRAIN),
        .term    (D_TERM),
        .at_term (d_at_term),
        .last    (d_last)
    );

`ifdef VEGETA_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_wstall_cycles <= '0;
            perf_astall_cycles <= '0;
        end else if (start_acc) begin
            perf_wstall_cycles <= '0;
            perf_astall_cycles <= '0;
        end else begin
            if ((state == LOAD0 || state == WAIT_W) && !w_valid
                && perf_wstall_cycles != '1)
                perf_wstall_cycles <= perf_wstall_cycles + 32'd1;
            if (state == COMPUTE && !act_valid
                && perf_astall_cycles != '1)
                perf_astall_cycles <= perf_astall_cycles + 32'd1;
        end
    end
`endif

endmodule
